// File: rtl/fdiv_quot.sv
// rtl/fdiv_quot.sv - fdiv final stage: mantissa multiply, normalize, pack IEEE-754 single quotient
module fdiv_quot #(
    parameter int          BIAS = 127,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sgn,
    input  logic [9:0]  exp_q,
    input  logic [23:0] x_man,
    input  logic [23:0] r_man,
    input  logic [1:0]  special,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q
);
    localparam logic signed [9:0] EMAX = 10'(2 * BIAS + 1);

    logic en;

    // stage 1: partial products
    logic        v1, sgn1;
    logic [9:0]  exp1;
    logic [1:0]  sp1;
    logic [23:0] hh, hl, lh, ll;

    // stage 2: normalized mantissa and exponent
    logic               v2, sgn2;
    logic signed [9:0]  e2;
    logic [1:0]         sp2;
    logic [23:0]        man2;

    logic [47:0]       p48;
    logic [24:0]       norm;
    logic signed [9:0] e_next;
    logic [31:0]       q_next;

    // returns {already_normalized, mantissa}; p48[47] cannot be set for legal operands
    function automatic logic [24:0] normalize(input logic [47:0] p);
        if (p[46])
            return {1'b1, p[46:23]};
        else
            return {1'b0, p[45:22]};
    endfunction

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            sgn1 <= 1'b0;
            exp1 <= '0;
            sp1  <= '0;
            hh   <= '0;
            hl   <= '0;
            lh   <= '0;
            ll   <= '0;
        end else if (en) begin
            v1   <= in_valid;
            sgn1 <= sgn;
            exp1 <= exp_q;
            sp1  <= special;
            hh   <= 24'(x_man[23:12]) * 24'(r_man[23:12]);
            hl   <= 24'(x_man[23:12]) * 24'(r_man[11:0]);
            lh   <= 24'(x_man[11:0])  * 24'(r_man[23:12]);
            ll   <= 24'(x_man[11:0])  * 24'(r_man[11:0]);
        end
    end

    always_comb begin
        p48    = {hh, 24'b0} + {12'b0, hl, 12'b0} + {12'b0, lh, 12'b0} + {24'b0, ll};
        norm   = normalize(p48);
        e_next = norm[24] ? $signed(exp1) : $signed(exp1) - 10'sd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            sgn2 <= 1'b0;
            e2   <= '0;
            sp2  <= '0;
            man2 <= '0;
        end else if (en) begin
            v2   <= v1;
            sgn2 <= sgn1;
            e2   <= e_next;
            sp2  <= sp1;
            man2 <= norm[23:0];
        end
    end

    // denormal results flush to signed zero, truncation only
    always_comb begin
        q_next = {sgn2, e2[7:0], man2[22:0]};
        case (sp2)
            2'b11: q_next = QNAN;
            2'b10: q_next = {sgn2, 8'hFF, 23'b0};
            2'b01: q_next = {sgn2, 31'b0};
            default: begin
                if (e2 <= 10'sd0)
                    q_next = {sgn2, 31'b0};
                else if (e2 >= EMAX)
                    q_next = {sgn2, 8'hFF, 23'b0};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (en) begin
            out_valid <= v2;
            q         <= q_next;
        end
    end
endmodule

// File: tb/tb_fdiv_quot.sv
// tb/tb_fdiv_quot.sv - scoreboard bench for fdiv_quot
module tb_fdiv_quot;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        sgn;
    logic [9:0]  exp_q;
    logic [23:0] x_man, r_man;
    logic [1:0]  special;
    logic        out_valid, out_ready;
    logic [31:0] q;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    fdiv_quot dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sgn(sgn), .exp_q(exp_q), .x_man(x_man), .r_man(r_man), .special(special),
        .out_valid(out_valid), .out_ready(out_ready), .q(q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [23:0] x;
        logic [23:0] r;
        logic [1:0]  sp;
        logic [31:0] exp_res;
    } vec_t;

    vec_t dir[$];

    function automatic logic [31:0] model(input logic s, input logic [9:0] e, input logic [23:0] x,
                                          input logic [23:0] r, input logic [1:0] sp);
        logic [47:0] p;
        logic [23:0] man;
        int          ee;
        if (sp == 2'b11) return 32'h7FC00000;
        if (sp == 2'b10) return {s, 8'hFF, 23'b0};
        if (sp == 2'b01) return {s, 31'b0};
        p  = 48'(x) * 48'(r);
        ee = int'($signed(e));
        if (p[46]) begin
            man = p[46:23];
        end else begin
            man = p[45:22];
            ee  = ee - 1;
        end
        if (ee <= 0) return {s, 31'b0};
        if (ee >= 255) return {s, 8'hFF, 23'b0};
        return {s, ee[7:0], man[22:0]};
    endfunction

    task automatic send(input logic s, input logic [9:0] e, input logic [23:0] x,
                        input logic [23:0] r, input logic [1:0] sp, input logic [31:0] want);
        int n = 0;
        sgn = s; exp_q = e; x_man = x; r_man = r; special = sp; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required=1", in_ready);
        end else begin
            sb.push_back(want);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
    endtask

    task automatic latency_check();
        int n = 1;
        #1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL latency: cycles=%0d required=3", n);
        end
    endtask

    // monitor: pops expected results whenever the DUT hands one over
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_q = '0;
        logic [31:0] want;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(out_valid && q == prev_q)) begin
                        errors++;
                        $display("FAIL stall_hold: out_valid=%0b q=%h required valid=1 q=%h", out_valid, q, prev_q);
                    end
                end
                if (out_valid && !out_ready) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: in_ready=%0b required=0", in_ready);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: q=%h required=no output", q);
                    end else begin
                        want = sb.pop_front();
                        if (q !== want) begin
                            errors++;
                            $display("FAIL result: q=%h required=%h", q, want);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_q     = q;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              s     exp      x         r         sp     expected
        dir.push_back('{1'b0, 10'd127, 24'h800000, 24'h800000, 2'b00, 32'h3F800000});
        dir.push_back('{1'b0, 10'd128, 24'hC00000, 24'h800000, 2'b00, 32'h40400000});
        dir.push_back('{1'b1, 10'd127, 24'h800000, 24'h600000, 2'b00, 32'hBF400000});
        dir.push_back('{1'b0, 10'd300, 24'h800000, 24'h800000, 2'b00, 32'h7F800000});
        dir.push_back('{1'b0, 10'd1,   24'h800000, 24'h600000, 2'b00, 32'h00000000});
        dir.push_back('{1'b0, 10'd5,   24'h800000, 24'h800000, 2'b11, 32'h7FC00000});
        dir.push_back('{1'b1, 10'd5,   24'h800000, 24'h800000, 2'b01, 32'h80000000});
        dir.push_back('{1'b1, 10'd5,   24'h800000, 24'h800000, 2'b10, 32'hFF800000});
        dir.push_back('{1'b0, 10'd254, 24'h800000, 24'h800000, 2'b00, 32'h7F000000});
        dir.push_back('{1'b0, 10'd255, 24'h800000, 24'h800000, 2'b00, 32'h7F800000});
        dir.push_back('{1'b0, 10'd1,   24'h800000, 24'h800000, 2'b00, 32'h00800000});
        dir.push_back('{1'b1, 10'h3F6, 24'hC00000, 24'h800000, 2'b00, 32'h80000000});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sgn = 1'b0; exp_q = '0; x_man = '0; r_man = '0; special = '0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: out_valid=%0b required=0", out_valid); end
        if (q !== 32'h0) begin errors++; $display("FAIL reset_q: q=%h required=00000000", q); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: in_ready=%0b required=1", in_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(dir[0].s, dir[0].e, dir[0].x, dir[0].r, dir[0].sp, dir[0].exp_res);
        in_valid = 1'b0;
        latency_check();
        @(negedge clk);
        drain();

        foreach (dir[i]) send(dir[i].s, dir[i].e, dir[i].x, dir[i].r, dir[i].sp, dir[i].exp_res);
        idle();
        drain();

        fork
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++)
            send(dir[i].s, dir[i].e, dir[i].x, dir[i].r, dir[i].sp, dir[i].exp_res);
        idle();
        drain();

        for (int i = 0; i < 3; i++)
            send(dir[i].s, dir[i].e, dir[i].x, dir[i].r, dir[i].sp, dir[i].exp_res);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: out_valid=%0b required=0", out_valid); end
        if (q !== 32'h0) begin errors++; $display("FAIL async_reset_q: q=%h required=00000000", q); end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(dir[1].s, dir[1].e, dir[1].x, dir[1].r, dir[1].sp, dir[1].exp_res);
        in_valid = 1'b0;
        latency_check();
        @(negedge clk);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic [9:0]  e;
            logic [23:0] x, r;
            s = 1'($urandom_range(0, 1));
            e = 10'($urandom_range(0, 500)) - 10'd100;
            x = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
            r = 24'($urandom_range(24'h400001, 24'h800000));
            send(s, e, x, r, 2'b00, model(s, e, x, r, 2'b00));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
